pool_result_writer: RTL and testbench

Sink for the pooled-output stream of the ReLU/max-pool lane array. Captures one PE_Num-lane pooled word per valid beat, tracks pooled row/column position, and writes each word into the on-chip feature-map buffer at base_addr + linear index. Signals completion once a full pooled map of (featmap_size>>1)² words has been written. Sits between the pooling stage and the next conv layer's input buffer.

---
 rtl/pool_result_writer_pkg.sv | 25 ++
 rtl/pooled_pos_counter.sv | 67 ++++++
 rtl/pool_result_writer.sv | 121 ++++++++++++
 tb/tb_pool_result_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_result_writer_pkg.sv
// pool_result_writer_pkg
//   Shared definitions for the pooled-output writer and its position counter:
//   writer state encoding, pooled side-length helper and LeNet map constants.
package pool_result_writer_pkg;

  localparam int unsigned FMAP_W = 5;

  // LeNet-5 conv map sizes and the resulting pooled side lengths.
  localparam int unsigned LENET_C1_MAP  = 28;
  localparam int unsigned LENET_C1_POOL = 14;
  localparam int unsigned LENET_C3_MAP  = 10;
  localparam int unsigned LENET_C3_POOL = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } pw_state_e;

  // 2x2 pooling halves the side; odd sizes floor.
  function automatic logic [FMAP_W-1:0] pooled_side(input logic [FMAP_W-1:0] featmap_size);
    return featmap_size >> 1;
  endfunction

endpackage

// File: rtl/pooled_pos_counter.sv
// pooled_pos_counter
//   Row/column/linear-index tracker over a square pooled map of side i_side.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     i_clr           clear all counters to zero
//     i_adv           advance one position
//     i_side          pooled side length P (>= 1 while advancing)
//     o_row, o_col    current position
//     o_lin           running linear index (row*P + col), wraps mod 2^idx_width
//     o_last          current position is the final one (P-1, P-1)
module pooled_pos_counter
  import pool_result_writer_pkg::*;
#(
  parameter int unsigned idx_width = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_adv,
  input  logic [FMAP_W-1:0]    i_side,
  output logic [FMAP_W-1:0]    o_row,
  output logic [FMAP_W-1:0]    o_col,
  output logic [idx_width-1:0] o_lin,
  output logic                 o_last
);

  localparam logic [FMAP_W-1:0]    POS_ONE = FMAP_W'(1);
  localparam logic [idx_width-1:0] LIN_ONE = idx_width'(1);

  logic [FMAP_W-1:0]    r_row;
  logic [FMAP_W-1:0]    r_col;
  logic [idx_width-1:0] r_lin;
  logic [FMAP_W-1:0]    w_side_m1;
  logic                 w_col_end;

  assign w_side_m1 = i_side - POS_ONE;
  assign w_col_end = (r_col == w_side_m1);
  assign o_last    = w_col_end && (r_row == w_side_m1);

  // Counters return to 0/0 after the final position so they idle at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_lin <= '0;
    end else if (i_adv) begin
      if (o_last) begin
        r_row <= '0;
        r_col <= '0;
        r_lin <= '0;
      end else begin
        r_lin <= r_lin + LIN_ONE;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + POS_ONE;
        end else begin
          r_col <= r_col + POS_ONE;
        end
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_lin = r_lin;

endmodule

// File: rtl/pool_result_writer.sv
// pool_result_writer
//   Sink for the pooled lane-array stream: writes one PE_Num-lane word per
//   valid beat to base_addr + linear index, pulses done after P*P words.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     start                 arm pulse; latches featmap_size and base_addr
//     featmap_size          pre-pool map side; P = featmap_size>>1
//     base_addr             first buffer address of this map
//     din_valid, din        pooled beat (lane i at din[i*dwidth +: dwidth])
//     wr_en/wr_addr/wr_data registered buffer write port
//     busy                  armed or finishing
//     done                  one-cycle completion pulse
//     err_stray             sticky: beat seen while idle
//     row_idx, col_idx      pooled position of the next expected beat
module pool_result_writer
  import pool_result_writer_pkg::*;
#(
  parameter int unsigned dwidth     = 16,
  parameter int unsigned PE_Num     = 8,
  parameter int unsigned addr_width = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [FMAP_W-1:0]        featmap_size,
  input  logic [addr_width-1:0]    base_addr,
  input  logic                     din_valid,
  input  logic [PE_Num*dwidth-1:0] din,
  output logic                     wr_en,
  output logic [addr_width-1:0]    wr_addr,
  output logic [PE_Num*dwidth-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_stray,
  output logic [FMAP_W-1:0]        row_idx,
  output logic [FMAP_W-1:0]        col_idx
);

  pw_state_e                r_state;
  pw_state_e                w_state_nxt;
  logic [FMAP_W-1:0]        r_p;
  logic [addr_width-1:0]    r_base;
  logic                     r_wr_en;
  logic [addr_width-1:0]    r_wr_addr;
  logic [PE_Num*dwidth-1:0] r_wr_data;
  logic                     r_err_stray;

  logic                     w_accept;
  logic                     w_clr;
  logic                     w_last;
  logic [addr_width-1:0]    w_lin;

  pooled_pos_counter #(
    .idx_width (addr_width)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_adv  (w_accept),
    .i_side (r_p),
    .o_row  (row_idx),
    .o_col  (col_idx),
    .o_lin  (w_lin),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = (pooled_side(featmap_size) == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (din_valid) begin
          w_accept = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_base      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_p    <= pooled_side(featmap_size);
        r_base <= base_addr;
      end
      r_wr_en <= w_accept;
      if (w_accept) begin
        // Address truncates to addr_width, so maps crossing the top wrap to 0.
        r_wr_addr <= r_base + w_lin;
        r_wr_data <= din;
      end
      if (r_state == ST_IDLE && din_valid) r_err_stray <= 1'b1;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err_stray = r_err_stray;

endmodule

// File: tb/tb_pool_result_writer.sv
module tb_pool_result_writer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   featmap_size;
  logic [9:0]   base_addr;
  logic         din_valid;
  logic [127:0] din;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         busy;
  logic         done;
  logic         err_stray;
  logic [4:0]   row_idx;
  logic [4:0]   col_idx;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int cnt_base;

  pool_result_writer #(
    .dwidth     (16),
    .PE_Num     (8),
    .addr_width (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .featmap_size (featmap_size),
    .base_addr    (base_addr),
    .din_valid    (din_valid),
    .din          (din),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err_stray    (err_stray),
    .row_idx      (row_idx),
    .col_idx      (col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [9:0] exp_addr, input logic exp_done);
    din_valid = 1'b1;
    din       = d;
    step();
    din_valid = 1'b0;
    din       = '0;
    chk("wr_en", wr_en, 1);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, d);
    chk("done", done, exp_done);
  endtask

  task automatic pulse_start(input logic [4:0] fs, input logic [9:0] base);
    start        = 1'b1;
    featmap_size = fs;
    base_addr    = base;
    step();
    start        = 1'b0;
  endtask

  function automatic logic [127:0] pat_uniform(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {8{v}};
  endfunction

  function automatic logic [127:0] pat_lanes(input int i);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[k*16 +: 16] = 16'(i * 16 + k) + 16'hA000;
    return p;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; featmap_size = '0; base_addr = '0;
    din_valid = 1'b0; din = '0;

    // Reset state
    step(); step();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_stray, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_col", col_idx, 0);
    rst_n = 1'b1;
    step();

    // Stray beat while idle
    din_valid = 1'b1; din = 128'h1234;
    step();
    din_valid = 1'b0; din = '0;
    chk("stray_wr_en", wr_en, 0);
    chk("stray_err", err_stray, 1);
    chk("stray_busy", busy, 0);
    step();
    chk("stray_err_hold", err_stray, 1);
    chk("stray_wr_en2", wr_en, 0);

    // featmap 28: P=14, 196 back-to-back beats at 0x040
    cnt_base = wr_cnt;
    pulse_start(5'd28, 10'h040);
    chk("m1_busy", busy, 1);
    chk("m1_row0", row_idx, 0);
    chk("m1_col0", col_idx, 0);
    for (int i = 0; i < 196; i++) begin
      if (i == 15) begin
        chk("m1_row_15", row_idx, 1);
        chk("m1_col_15", col_idx, 1);
      end
      send_beat(pat_uniform(i), 10'(32'h040 + i), i == 195);
      if (i == 195) chk("m1_busy_done", busy, 1);
    end
    step();
    chk("m1_busy_end", busy, 0);
    chk("m1_done_end", done, 0);
    chk("m1_wr_en_end", wr_en, 0);
    chk("m1_row_idle", row_idx, 0);
    chk("m1_col_idle", col_idx, 0);
    chk("m1_wr_count", 32'(wr_cnt - cnt_base), 196);
    chk("m1_err_sticky", err_stray, 1);

    // featmap 10: P=5, base 0x3F0 wraps, gapped beats, mid-map start ignored
    cnt_base = wr_cnt;
    pulse_start(5'd10, 10'h3F0);
    for (int i = 0; i < 25; i++) begin
      if (i == 11) begin
        chk("m2_row_11", row_idx, 2);
        chk("m2_col_11", col_idx, 1);
        pulse_start(5'd28, 10'h000);
        chk("m2_restart_wr", wr_en, 0);
        chk("m2_restart_busy", busy, 1);
      end
      for (int g = 0; g < i % 4; g++) begin
        step();
        chk("m2_gap_wr_en", wr_en, 0);
      end
      if (i == 24) begin
        chk("m2_row_last", row_idx, 4);
        chk("m2_col_last", col_idx, 4);
      end
      send_beat(pat_lanes(i), 10'(32'h3F0 + i), i == 24);
    end
    step();
    chk("m2_busy_end", busy, 0);
    chk("m2_done_end", done, 0);
    chk("m2_wr_count", 32'(wr_cnt - cnt_base), 25);

    // featmap 1: P=0, done one cycle after start, no writes
    cnt_base = wr_cnt;
    pulse_start(5'd1, 10'h055);
    chk("m3_done", done, 1);
    chk("m3_busy", busy, 1);
    chk("m3_wr_en", wr_en, 0);
    step();
    chk("m3_done_end", done, 0);
    chk("m3_busy_end", busy, 0);
    chk("m3_wr_count", 32'(wr_cnt - cnt_base), 0);

    // Reset mid-map after 7 beats of a P=14 map
    pulse_start(5'd28, 10'h000);
    for (int i = 0; i < 7; i++) send_beat(pat_uniform(i + 300), 10'(i), 1'b0);
    rst_n = 1'b0;
    step();
    chk("mr_wr_en", wr_en, 0);
    chk("mr_wr_addr", wr_addr, 0);
    chk("mr_wr_data", wr_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err_stray, 0);
    chk("mr_row", row_idx, 0);
    chk("mr_col", col_idx, 0);
    rst_n = 1'b1;
    step();
    chk("mr_no_done", done, 0);
    chk("mr_idle_busy", busy, 0);

    // Fresh map after reset completes normally
    cnt_base = wr_cnt;
    pulse_start(5'd10, 10'h100);
    for (int i = 0; i < 25; i++) send_beat(pat_lanes(i + 40), 10'(32'h100 + i), i == 24);
    step();
    chk("m4_busy_end", busy, 0);
    chk("m4_wr_count", 32'(wr_cnt - cnt_base), 25);
    chk("m4_err_clear", err_stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
